// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, datapath width and the registered response record.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            less;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; undefined control codes yield result 0 (zero=1) while less still reports signed a<b.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output alu_rsp_t        rsp
);

  logic [XLEN-1:0] res;

  always_comb begin
    res = '0;
    case (ctrl)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = $signed(a) >>> b[4:0];
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      default:  res = '0;
    endcase
  end

  always_comb begin
    rsp.result = res;
    rsp.zero   = (res == '0);
    rsp.less   = $signed(a) < $signed(b);
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone eligible requester always wins, a conflict goes to the one not granted last.
module rr_arb2 #(
  parameter int PRIO_INIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic elig0,
  input  logic elig1,
  output logic gnt0,
  output logic gnt1
);

  // last_grant resets to the opposite of PRIO_INIT so the first conflict goes to PRIO_INIT
  localparam logic LAST_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt0 = elig0 && (!elig1 || last_grant_q);
    gnt1 = elig1 && (!elig0 || !last_grant_q);
    last_grant_d = last_grant_q;
    if (gnt1)      last_grant_d = 1'b1;
    else if (gnt0) last_grant_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= LAST_RST;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by two requesters, round-robin, response registered one cycle after acceptance and held until drained.
// Optional saturating grant/conflict counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_ctrl,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_less,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_ctrl,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_less
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_grant0,
  output logic [CNT_W-1:0] stat_grant1,
  output logic [CNT_W-1:0] stat_conflict
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic            elig0, elig1, gnt0, gnt1;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_ctrl;
  alu_rsp_t        alu_out;
  alu_rsp_t        rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic            rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;

  // A slot being drained this cycle is free for a new grant in the same cycle
  always_comb begin
    elig0 = req0_valid && (!rsp0_vld_q || rsp0_ready);
    elig1 = req1_valid && (!rsp1_vld_q || rsp1_ready);
  end

  rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk   (clk),
    .rst   (reset),
    .elig0 (elig0),
    .elig1 (elig1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    alu_a    = gnt1 ? req1_a    : req0_a;
    alu_b    = gnt1 ? req1_b    : req0_b;
    alu_ctrl = gnt1 ? req1_ctrl : req0_ctrl;
  end

  alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .ctrl (alu_ctrl),
    .rsp  (alu_out)
  );

  always_comb begin
    rsp0_d     = gnt0 ? alu_out : rsp0_q;
    rsp1_d     = gnt1 ? alu_out : rsp1_q;
    rsp0_vld_d = gnt0 || (rsp0_vld_q && !rsp0_ready);
    rsp1_vld_d = gnt1 || (rsp1_vld_q && !rsp1_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_q     <= '0;
      rsp1_q     <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
    end else begin
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
    end
  end

  always_comb begin
    req0_ready  = gnt0;
    req1_ready  = gnt1;
    rsp0_valid  = rsp0_vld_q;
    rsp0_result = rsp0_q.result;
    rsp0_zero   = rsp0_q.zero;
    rsp0_less   = rsp0_q.less;
    rsp1_valid  = rsp1_vld_q;
    rsp1_result = rsp1_q.result;
    rsp1_zero   = rsp1_q.zero;
    rsp1_less   = rsp1_q.less;
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_g0_q, cnt_g0_d, cnt_g1_q, cnt_g1_d, cnt_cf_q, cnt_cf_d;

  // Counters stick at all-ones rather than wrapping
  always_comb begin
    cnt_g0_d = (gnt0 && !(&cnt_g0_q)) ? cnt_g0_q + CNT_W'(1) : cnt_g0_q;
    cnt_g1_d = (gnt1 && !(&cnt_g1_q)) ? cnt_g1_q + CNT_W'(1) : cnt_g1_q;
    cnt_cf_d = (elig0 && elig1 && !(&cnt_cf_q)) ? cnt_cf_q + CNT_W'(1) : cnt_cf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_g0_q <= '0;
      cnt_g1_q <= '0;
      cnt_cf_q <= '0;
    end else begin
      cnt_g0_q <= cnt_g0_d;
      cnt_g1_q <= cnt_g1_d;
      cnt_cf_q <= cnt_cf_d;
    end
  end

  always_comb begin
    stat_grant0   = cnt_g0_q;
    stat_grant1   = cnt_g1_q;
    stat_conflict = cnt_cf_q;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: per-cycle vector table plus hold, back-to-back, reset and stats sequences.
module tb_alu_share_arbiter;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_less;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_less;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [3:0]  req0_ctrl, req1_ctrl;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.PRIO_INIT(0), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_less   (rsp0_less),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_less   (rsp1_less)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  typedef struct {
    logic        r0v;
    logic [31:0] r0a, r0b;
    logic [3:0]  r0c;
    logic        s0r;
    logic        r1v;
    logic [31:0] r1a, r1b;
    logic [3:0]  r1c;
    logic        s1r;
    logic        e_rdy0, e_rdy1;
    logic        e_v0;
    logic [31:0] e_res0;
    logic        e_z0, e_l0;
    logic        e_v1;
    logic [31:0] e_res1;
    logic        e_z1, e_l1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One requester alone, both rsp_ready high
  function automatic vec_t solo(input bit who, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] c, input logic [31:0] res,
                                input logic z, input logic l);
    vec_t v;
    v = '{r0v: !who, r0a: a, r0b: b, r0c: c, s0r: 1'b1,
          r1v: who, r1a: a, r1b: b, r1c: c, s1r: 1'b1,
          e_rdy0: !who, e_rdy1: who,
          e_v0: !who, e_res0: res, e_z0: z, e_l0: l,
          e_v1: who, e_res1: res, e_z1: z, e_l1: l};
    return v;
  endfunction

  // Both valid: req0 ADD 1+1, req1 SLT -1<1
  function automatic vec_t pair(input bit winner);
    vec_t v;
    v = '{r0v: 1'b1, r0a: 32'd1, r0b: 32'd1, r0c: 4'b0000, s0r: 1'b1,
          r1v: 1'b1, r1a: 32'hFFFF_FFFF, r1b: 32'd1, r1c: 4'b1000, s1r: 1'b1,
          e_rdy0: !winner, e_rdy1: winner,
          e_v0: !winner, e_res0: 32'd2, e_z0: 1'b0, e_l0: 1'b0,
          e_v1: winner, e_res1: 32'd1, e_z1: 1'b0, e_l1: 1'b1};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0_valid = v.r0v; req0_a = v.r0a; req0_b = v.r0b; req0_ctrl = v.r0c; rsp0_ready = v.s0r;
    req1_valid = v.r1v; req1_a = v.r1a; req1_b = v.r1b; req1_ctrl = v.r1c; rsp1_ready = v.s1r;
  endtask

  task automatic set0(input logic vld, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic rdy);
    req0_valid = vld; req0_a = a; req0_b = b; req0_ctrl = c; rsp0_ready = rdy;
  endtask

  task automatic set1(input logic vld, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic rdy);
    req1_valid = vld; req1_a = a; req1_b = b; req1_ctrl = c; rsp1_ready = rdy;
  endtask

  // Entered and left at a falling edge; readies checked before the rising edge, responses after it
  task automatic run_vec(input int idx, input vec_t v);
    drive(v);
    #1;
    chk($sformatf("v%0d req0_ready", idx), {31'b0, req0_ready}, {31'b0, v.e_rdy0});
    chk($sformatf("v%0d req1_ready", idx), {31'b0, req1_ready}, {31'b0, v.e_rdy1});
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp0_valid", idx), {31'b0, rsp0_valid}, {31'b0, v.e_v0});
    chk($sformatf("v%0d rsp1_valid", idx), {31'b0, rsp1_valid}, {31'b0, v.e_v1});
    if (v.e_v0) begin
      chk($sformatf("v%0d rsp0_result", idx), rsp0_result, v.e_res0);
      chk($sformatf("v%0d rsp0_zero", idx), {31'b0, rsp0_zero}, {31'b0, v.e_z0});
      chk($sformatf("v%0d rsp0_less", idx), {31'b0, rsp0_less}, {31'b0, v.e_l0});
    end
    if (v.e_v1) begin
      chk($sformatf("v%0d rsp1_result", idx), rsp1_result, v.e_res1);
      chk($sformatf("v%0d rsp1_zero", idx), {31'b0, rsp1_zero}, {31'b0, v.e_z1});
      chk($sformatf("v%0d rsp1_less", idx), {31'b0, rsp1_less}, {31'b0, v.e_l1});
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[14];
    tbl[0]  = solo(0, 32'd5,         32'd3,         4'b0001, 32'd2,         1'b0, 1'b0);
    tbl[1]  = solo(1, 32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0,         1'b1, 1'b1);
    tbl[2]  = solo(0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0010, 32'h0000_F000, 1'b0, 1'b1);
    tbl[3]  = solo(1, 32'h0000_000F, 32'h0000_00F0, 4'b0011, 32'h0000_00FF, 1'b0, 1'b1);
    tbl[4]  = solo(0, 32'hAAAA_5555, 32'hAAAA_5555, 4'b0100, 32'd0,         1'b1, 1'b0);
    tbl[5]  = solo(1, 32'd1,         32'd31,        4'b0101, 32'h8000_0000, 1'b0, 1'b1);
    tbl[6]  = solo(0, 32'h8000_0000, 32'd4,         4'b0110, 32'h0800_0000, 1'b0, 1'b1);
    tbl[7]  = solo(1, 32'h8000_0000, 32'd4,         4'b0111, 32'hF800_0000, 1'b0, 1'b1);
    tbl[8]  = solo(0, 32'hFFFF_FFFF, 32'd1,         4'b1000, 32'd1,         1'b0, 1'b1);
    tbl[9]  = solo(1, 32'hFFFF_FFFF, 32'd1,         4'b1001, 32'd0,         1'b1, 1'b1);
    tbl[10] = solo(0, 32'd3,         32'd9,         4'b1111, 32'd0,         1'b1, 1'b1);
    tbl[11] = solo(1, 32'd9,         32'd3,         4'b1010, 32'd0,         1'b1, 1'b0);
    tbl[12] = pair(0);
    tbl[13] = pair(1);

    reset = 1'b1;
    set0(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    #2;
    chk("reset rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("reset rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("reset rsp0_result", rsp0_result, 32'd0);
    chk("reset rsp1_result", rsp1_result, 32'd0);
    chk("reset flags", {28'b0, rsp0_zero, rsp0_less, rsp1_zero, rsp1_less}, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("reset stat_conflict", 32'(stat_conflict), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

    // Continuous contention alternates grants; last grant was requester 1
    for (int i = 0; i < 4; i++) run_vec(100 + i, pair(i % 2 == 1));

    // Hold: rsp0 = SUB 7-7 stays parked while requester 1 keeps going
    set0(1'b1, 32'd7, 32'd7, 4'b0001, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    #1;
    chk("hold accept req0_ready", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    chk("hold rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      set0(1'b1, 32'd1, 32'd1, 4'b0000, 1'b0);
      set1(1'b1, 32'(k), 32'(k), 4'b0000, 1'b1);
      #1;
      chk($sformatf("hold%0d req0_ready", k), {31'b0, req0_ready}, 32'd0);
      chk($sformatf("hold%0d req1_ready", k), {31'b0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("hold%0d rsp0", k), {rsp0_valid, rsp0_zero, rsp0_less, 29'b0}, {3'b110, 29'b0});
      chk($sformatf("hold%0d rsp0_result", k), rsp0_result, 32'd0);
      chk($sformatf("hold%0d rsp1_result", k), rsp1_result, 32'(2 * k));
      @(negedge clk);
    end

    // Back-to-back: drain and re-grant requester 0 in the same cycle
    set0(1'b1, 32'h8000_0000, 32'd1, 4'b0111, 1'b1);
    set1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    #1;
    chk("b2b req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("b2b rsp0_valid before", {31'b0, rsp0_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b rsp0_valid after", {31'b0, rsp0_valid}, 32'd1);
    chk("b2b rsp0_result", rsp0_result, 32'hC000_0000);
    chk("b2b rsp0_less", {31'b0, rsp0_less}, 32'd1);
    @(negedge clk);

    // Park both responses, then assert reset mid-cycle
    set0(1'b1, 32'd3, 32'd4, 4'b0000, 1'b0);
    set1(1'b1, 32'd5, 32'd6, 4'b0000, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("pre-reset both held", {30'b0, rsp0_valid, rsp1_valid}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("async reset rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("async reset rsp1_result", rsp1_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set0(1'b1, 32'd3, 32'd4, 4'b0000, 1'b1);
    set1(1'b1, 32'd5, 32'd6, 4'b0000, 1'b1);
    #1;
    chk("post-reset conflict req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("post-reset conflict req1_ready", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("post-reset rsp0_result", rsp0_result, 32'd7);
    chk("post-reset rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    @(negedge clk);

`ifdef ALU_ARB_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set0(1'b1, 32'd1, 32'd1, 4'b0000, 1'b1);
    set1(1'b1, 32'd2, 32'd2, 4'b0000, 1'b1);
    repeat (20) @(negedge clk);
    set0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    set1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    #1;
    chk("stat_conflict saturated", 32'(stat_conflict), 32'd15);
    chk("stat_grant0", 32'(stat_grant0), 32'd10);
    chk("stat_grant1", 32'(stat_grant1), 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
